// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO; queued frames go out back-to-back.
// Defining UART_TX_PARITY_EN inserts a parity bit (sense set by PARITY_ODD) after data bit 7.

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    s_IDLE   = 3'd0,
    s_START  = 3'd1,
    s_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    s_PARITY = 3'd3,
`endif
    s_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       fifo_head;
  logic             fifo_empty;
  logic             bit_last;
  logic             push;
  logic             pop;

  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign bit_last   = (clk_cnt_q == CNT_LAST);
  assign pop        = !fifo_empty && ((state_q == s_IDLE) || ((state_q == s_STOP) && bit_last));
  // A full FIFO still accepts on the edge that pops, so push+pop keeps the count steady.
  assign o_Tx_Ready = (count_q != COUNT_FULL) || pop;
  assign push       = i_Tx_DV && o_Tx_Ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = (state_q == s_STOP) && (clk_cnt_q == CNT_DONE);
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      s_IDLE: begin
        clk_cnt_d = '0;
        serial_d  = 1'b1;
        active_d  = 1'b0;
      end
      s_START: begin
        if (bit_last) begin
          state_d   = s_DATA;
          clk_cnt_d = '0;
          serial_d  = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      s_DATA: begin
        if (bit_last) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d  = s_PARITY;
            serial_d = parity_q;
`else
            state_d  = s_STOP;
            serial_d = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      s_PARITY: begin
        if (bit_last) begin
          state_d   = s_STOP;
          clk_cnt_d = '0;
          serial_d  = 1'b1;
        end
      end
`endif
      s_STOP: begin
        serial_d = 1'b1;
        if (bit_last) begin
          state_d   = s_IDLE;
          clk_cnt_d = '0;
          active_d  = 1'b0;
        end
      end
      default: begin
        state_d   = s_IDLE;
        clk_cnt_d = '0;
        serial_d  = 1'b1;
        active_d  = 1'b0;
      end
    endcase

    // Loading a byte overrides the idle/stop exit so the next start bit follows immediately.
    if (pop) begin
      state_d   = s_START;
      clk_cnt_d = '0;
      bit_idx_d = '0;
      shift_d   = fifo_head;
      serial_d  = 1'b0;
      active_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d  = (^fifo_head) ^ PARITY_ODD;
`endif
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= s_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Fifo_Count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: frame-level reference model checked every cycle, plus
// table-driven frame vectors and directed back-to-back / full / simultaneous / reset sequences.

module tb_uart_tx_fifo;

  localparam int C  = 4;
  localparam int D  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam int NV = 2;
`else
  localparam int FB = 10;
  localparam int NV = 5;
`endif
  localparam int FRAME = FB * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
  logic [2:0] o_Fifo_Count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Tx_DV     (dv),
    .i_Tx_Byte   (din),
    .o_Tx_Ready  (o_Tx_Ready),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Tx_Active (o_Tx_Active),
    .o_Tx_Done   (o_Tx_Done),
    .o_Fifo_Count(o_Fifo_Count)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Line level of frame bit k for byte b: start, 8 data LSB-first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Reference model: a byte queue plus the start edge of the frame currently on the line.
  int         n = 0;
  bit         busy = 1'b0;
  int         fstart = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] q[$];
  int         m_pre;
  bit         m_popped;

  always @(posedge clk) begin
    n++;
    if (rst) begin
      q.delete();
      busy = 1'b0;
    end else begin
      m_pre    = q.size();
      m_popped = 1'b0;
      if (busy && (n - fstart == FRAME)) busy = 1'b0;
      if (!busy && q.size() > 0) begin
        cur      = q.pop_front();
        fstart   = n;
        busy     = 1'b1;
        m_popped = 1'b1;
      end
      if (dv && (m_pre < D || m_popped)) q.push_back(din);
    end
  end

  int mk;
  always @(negedge clk) begin
    if (chk_en) begin
      mk = n - fstart;
      check("serial", int'(o_Tx_Serial), busy ? int'(frame_bit(cur, mk / C)) : 1);
      check("active", int'(o_Tx_Active), int'(busy));
      check("done",   int'(o_Tx_Done),   int'(busy && mk == FRAME - 1));
      check("count",  int'(o_Fifo_Count), q.size());
      check("ready",  int'(o_Tx_Ready),  int'(q.size() < D || !busy || mk == FRAME - 1));
    end
  end

  typedef struct {
    logic [7:0]  tx_byte;
    logic [10:0] frame;
    int          done_at;
  } vec_t;

  vec_t vecs[NV];

  task automatic wait_to(input int target);
    while (n < target) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(o_Fifo_Count == 0 && !o_Tx_Active) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: transmitter still busy after %0d cycles", t);
    end
  endtask

  int e0, act_cnt, nd, t, lows;

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{tx_byte: 8'h07, frame: 11'h60E, done_at: 44};
    vecs[1] = '{tx_byte: 8'h03, frame: 11'h406, done_at: 44};
`else
    vecs[0] = '{tx_byte: 8'hA5, frame: 11'h34A, done_at: 40};
    vecs[1] = '{tx_byte: 8'h00, frame: 11'h200, done_at: 40};
    vecs[2] = '{tx_byte: 8'hFF, frame: 11'h3FE, done_at: 40};
    vecs[3] = '{tx_byte: 8'h55, frame: 11'h2AA, done_at: 40};
    vecs[4] = '{tx_byte: 8'h3C, frame: 11'h278, done_at: 40};
`endif

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_serial", int'(o_Tx_Serial), 1);
    check("rst_active", int'(o_Tx_Active), 0);
    check("rst_done",   int'(o_Tx_Done),   0);
    check("rst_count",  int'(o_Fifo_Count), 0);
    check("rst_ready",  int'(o_Tx_Ready),  1);
    rst = 1'b0;

    // Table-driven single frames: line level mid-bit, done position, active release.
    for (int i = 0; i < NV; i++) begin
      wait_idle();
      @(negedge clk);
      dv  = 1'b1;
      din = vecs[i].tx_byte;
      @(negedge clk);
      dv = 1'b0;
      e0 = n;
      for (int k = 0; k < FB; k++) begin
        wait_to(e0 + 1 + k * C + 1);
        check($sformatf("vec%0d_bit%0d", i, k), int'(o_Tx_Serial), int'(vecs[i].frame[k]));
      end
      wait_to(e0 + vecs[i].done_at - 1);
      check($sformatf("vec%0d_done_early", i), int'(o_Tx_Done), 0);
      wait_to(e0 + vecs[i].done_at);
      check($sformatf("vec%0d_done", i), int'(o_Tx_Done), 1);
      wait_to(e0 + vecs[i].done_at + 1);
      check($sformatf("vec%0d_active_end", i), int'(o_Tx_Active), 0);
      $display("vector %0d: byte 0x%02h sent", i, vecs[i].tx_byte);
    end

    // Back-to-back: three writes on consecutive edges.
    wait_idle();
    @(negedge clk);
    dv  = 1'b1;
    din = 8'h00;
    e0  = n + 1;
    act_cnt = 0;
    nd = 0;
    for (int k = 0; k < FRAME * 3 + 10; k++) begin
      @(negedge clk);
      if (k == 0) din = 8'hFF;
      else if (k == 1) din = 8'h55;
      else dv = 1'b0;
      if (o_Tx_Active) act_cnt++;
      if (o_Tx_Done) begin
        check("b2b_done_at", k, FRAME * (nd + 1));
        nd++;
      end
    end
    check("b2b_active_cycles", act_cnt, FRAME * 3);
    check("b2b_done_pulses", nd, 3);
    $display("back-to-back: active %0d cycles, %0d done pulses", act_cnt, nd);

    // Full: six writes while busy, only four fit.
    wait_idle();
    @(negedge clk);
    dv  = 1'b1;
    din = 8'h11;
    @(negedge clk);
    dv = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      dv  = 1'b1;
      din = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    dv = 1'b0;
    check("full_count", int'(o_Fifo_Count), 4);
    check("full_ready", int'(o_Tx_Ready), 0);
    $display("full: count %0d ready %0d", o_Fifo_Count, o_Tx_Ready);

    // Simultaneous push and pop with the FIFO full.
    t = 0;
    while (!o_Tx_Done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("simul_done_seen", int'(o_Tx_Done), 1);
    check("simul_pre_count", int'(o_Fifo_Count), 4);
    dv  = 1'b1;
    din = 8'hC3;
    @(negedge clk);
    dv = 1'b0;
    check("simul_count", int'(o_Fifo_Count), 4);
    $display("simultaneous: count after push+pop %0d", o_Fifo_Count);
    wait_idle();

    // Reset during data bit 3 of 0x3C with two bytes queued.
    @(negedge clk);
    dv  = 1'b1;
    din = 8'h3C;
    @(negedge clk);
    din = 8'h81;
    e0  = n;
    @(negedge clk);
    din = 8'h7E;
    @(negedge clk);
    dv = 1'b0;
    wait_to(e0 + 1 + 4 * C + 2);
    check("mid_bit3", int'(o_Tx_Serial), 1);
    check("mid_count", int'(o_Fifo_Count), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_serial", int'(o_Tx_Serial), 1);
    check("mid_rst_count",  int'(o_Fifo_Count), 0);
    check("mid_rst_active", int'(o_Tx_Active), 0);
    nd = 0;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_Tx_Done) nd++;
      if (!o_Tx_Serial) lows++;
    end
    check("mid_rst_no_done", nd, 0);
    check("mid_rst_line_idle", lows, 0);
    $display("reset mid-frame: done pulses %0d, low cycles %0d", nd, lows);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      dv  = ($urandom_range(0, 99) < 12);
      din = 8'($urandom);
      rst = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    dv  = 1'b0;
    rst = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    $display("random phase complete");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
